regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  XLEN, 32, data width in bits
  NREGS, 32, number of architectural registers (power of two, >= 2)
  NREAD, 2, number of independent read ports (>= 1)
  AW, $clog2(NREGS), register address width (derived, not overridden)
REQ-002 Ports SHALL be, one per line: name direction width meaning.
  clk  input  1  single clock; all state updates on rising edge
  reset  input  1  asynchronous, active-low reset
  rd_addr  input  NREAD*AW  packed read addresses; port i at [i*AW +: AW]
  rd_data  output  NREAD*XLEN  packed read data; port i at [i*XLEN +: XLEN]
  rd_busy  output  NREAD  port i source register has an outstanding producer
  wr_en  input  1  writeback strobe
  wr_addr  input  AW  writeback destination
  wr_data  input  XLEN  writeback value
  iss_en  input  1  issue strobe; marks iss_addr as pending producer
  iss_addr  input  AW  destination of issued instruction
  busy_vec  output  NREGS  per-register pending bit, bit r = register r

Function
REQ-003 Register 0 SHALL read 0 on every port, never be written and never be busy.
REQ-004 rd_data SHALL be combinational from the array and rd_addr (zero-cycle read latency).
REQ-005 On a rising edge with wr_en=1 and wr_addr!=0, array[wr_addr] SHALL take wr_data; visible on rd_data from the following cycle.
REQ-006 Scoreboard: iss_en=1 with iss_addr!=0 SHALL set busy[iss_addr] at the edge; wr_en=1 SHALL clear busy[wr_addr] at the edge.
REQ-007 Same-edge iss_en and wr_en to the same nonzero address: busy SHALL end set (newer producer wins), data still written.
REQ-008 Same-edge iss_en and wr_en to different addresses SHALL both take effect.
REQ-009 Issue to an already-busy register SHALL leave it busy (no counting); one writeback clears it.
REQ-010 Writeback to a non-busy register SHALL write data and leave busy clear.
REQ-011 rd_busy[i] SHALL equal busy_vec[rd_addr[i]] except as modified by REQ-014.
REQ-012 Multiple read ports with equal addresses SHALL return identical data and busy.

Reset
REQ-013 reset=0 SHALL asynchronously clear all registers to 0 and busy_vec to 0; rd_data then reads 0 and rd_busy 0 on every port; pending issues at reset assertion are discarded; normal operation resumes on the first rising edge after reset=1.

Configuration
REQ-014 Macro REGFILE_BYPASS_EN defined: when wr_en=1, wr_addr!=0 and wr_addr==rd_addr[i], rd_data[i] SHALL equal wr_data and rd_busy[i] SHALL be 0 in that same cycle; undefined: rd_data[i] SHALL show the old array value and rd_busy[i] the unmodified busy bit until the next edge.

Structure
REQ-015 Package riscv_pkg SHALL hold default XLEN/NREGS constants and the reg_addr_t typedef; regfile_sb SHALL import it.
REQ-016 The busy-bit logic SHALL be a sub-module regfile_scoreboard (inputs iss/wr strobes and addresses, output busy_vec); the data array and read/bypass muxing stay in regfile_sb.

Verification
REQ-017 Write 200 to r2 then 10 to r5 on consecutive edges, read r2/r5 next cycle -> rd_data 200 and 10, rd_busy 0.
REQ-018 wr_en with wr_addr=0, wr_data=0xDEADBEEF; iss_en with iss_addr=0 -> r0 reads 0 on all ports, busy_vec[0]=0.
REQ-019 Issue r7, read r7 -> rd_busy=1; wr r7=0x55 -> with REGFILE_BYPASS_EN same-cycle rd_data=0x55, rd_busy=0; without, old value and rd_busy=1 that cycle, 0x55 and 0 next cycle.
REQ-020 Same-edge iss_en r9 and wr_en r9=42 -> r9 reads 42, busy_vec[9]=1; second wr r9=43 -> busy_vec[9]=0.
REQ-021 Load r2=200, r5=10, issue r5, assert reset=0 between edges -> rd_data 0 and busy_vec 0 immediately, before the next edge.
REQ-022 NREAD=4, NREGS=64 build: ports read r0, r63, r63, r31 after writing r63=1 and r31=2 -> 0, 1, 1, 2.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg -- shared register-file constants.
// Holds the default data width and register count used by regfile_sb,
// plus the architectural register address type for the default build.
// No ports.
package riscv_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int AW_DEFAULT    = $clog2(NREGS_DEFAULT);

    typedef logic [AW_DEFAULT-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if -- bundle of the register-file read, writeback and issue
// signals, so a core (or a bench) can carry them as one object.
//   master : drives read addresses, writeback and issue; sees read data,
//            per-port busy and the full busy vector.
//   slave  : the register-file side of the same signals.
interface regfile_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NREAD = 2,
    localparam int AW   = $clog2(NREGS)
);
    logic [NREAD*AW-1:0]   rd_addr;
    logic [NREAD*XLEN-1:0] rd_data;
    logic [NREAD-1:0]      rd_busy;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [XLEN-1:0]       wr_data;
    logic                  iss_en;
    logic [AW-1:0]         iss_addr;
    logic [NREGS-1:0]      busy_vec;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data, rd_busy, busy_vec
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard -- one pending-producer bit per architectural register.
//   clk, reset (async, active-low)
//   iss_en/iss_addr : issue marks the destination as pending
//   wr_en/wr_addr   : writeback clears the pending bit
//   busy_vec        : registered pending bits, bit r = register r
// Register 0 is never pending.
module regfile_scoreboard #(
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_addr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    output logic [NREGS-1:0] busy_vec
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Clear first, then set: an issue and a writeback to the same register
    // on one edge leaves it pending, because the issue is the newer producer.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (iss_en && (iss_addr != '0)) begin
            busy_d[iss_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb -- multi-port register file with a pending-producer scoreboard.
//   clk, reset (async, active-low: clears data and busy bits)
//   rd_addr/rd_data/rd_busy : NREAD combinational read ports, packed
//   wr_en/wr_addr/wr_data   : writeback, written on the rising edge
//   iss_en/iss_addr         : issue, marks destination pending
//   busy_vec                : per-register pending bits
// Register 0 reads zero, ignores writes and is never busy.
// Optional macro REGFILE_BYPASS_EN: a writeback forwards its data (and a
// cleared busy bit) to matching read ports in the same cycle.
module regfile_sb
    import riscv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREGS = NREGS_DEFAULT,
    parameter int NREAD = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD*XLEN-1:0] rd_data,
    output logic [NREAD-1:0]      rd_busy,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [XLEN-1:0]       wr_data,
    input  logic                  iss_en,
    input  logic [AW-1:0]         iss_addr,
    output logic [NREGS-1:0]      busy_vec
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (wr_en && (wr_addr != '0)) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .busy_vec (busy_vec)
    );

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            busy;

        assign addr = rd_addr[i*AW +: AW];

        always_comb begin
            data = regs_q[addr];
            busy = busy_vec[addr];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (wr_addr != '0) && (wr_addr == addr)) begin
                data = wr_data;
                busy = 1'b0;
            end
`endif
            // r0 is hardwired regardless of array contents.
            if (addr == '0) begin
                data = '0;
                busy = 1'b0;
            end
        end

        assign rd_data[i*XLEN +: XLEN] = data;
        assign rd_busy[i]              = busy;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb -- randomized and directed stimulus for regfile_sb in a
// 4-read-port, 64-register build, checked against a behavioural model.
module tb_regfile_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 64;
    localparam int NREAD = 4;
    localparam int AW    = $clog2(NREGS);
    localparam int W     = NREAD*XLEN + NREAD + NREGS;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) rf_if ();

    regfile_sb #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NREAD (NREAD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (rf_if.rd_addr),
        .rd_data  (rf_if.rd_data),
        .rd_busy  (rf_if.rd_busy),
        .wr_en    (rf_if.wr_en),
        .wr_addr  (rf_if.wr_addr),
        .wr_data  (rf_if.wr_data),
        .iss_en   (rf_if.iss_en),
        .iss_addr (rf_if.iss_addr),
        .busy_vec (rf_if.busy_vec)
    );

    // ---------------- reference model ----------------
    int unsigned   m_regs [NREGS];
    bit            m_busy [NREGS];

    function automatic void model_reset();
        for (int r = 0; r < NREGS; r++) begin
            m_regs[r] = 0;
            m_busy[r] = 0;
        end
    endfunction

    // What the outputs should show right now, given model state and inputs.
    function automatic logic [W-1:0] expect_now();
        logic [NREAD*XLEN-1:0] d;
        logic [NREAD-1:0]      b;
        logic [NREGS-1:0]      bv;
        int                    a;
        d = '0;
        b = '0;
        for (int i = 0; i < NREAD; i++) begin
            a = int'(rf_if.rd_addr[i*AW +: AW]);
            if (a == 0) begin
                d[i*XLEN +: XLEN] = '0;
                b[i] = 1'b0;
            end else begin
                d[i*XLEN +: XLEN] = m_regs[a];
                b[i] = m_busy[a];
`ifdef REGFILE_BYPASS_EN
                if (rf_if.wr_en && int'(rf_if.wr_addr) == a) begin
                    d[i*XLEN +: XLEN] = rf_if.wr_data;
                    b[i] = 1'b0;
                end
`endif
            end
        end
        for (int r = 0; r < NREGS; r++) bv[r] = m_busy[r];
        return {d, b, bv};
    endfunction

    // Effect of the coming rising edge on architectural state.
    function automatic void model_edge();
        int wa;
        int ia;
        wa = int'(rf_if.wr_addr);
        ia = int'(rf_if.iss_addr);
        if (rf_if.wr_en && wa != 0) m_regs[wa] = rf_if.wr_data;
        if (rf_if.wr_en) m_busy[wa] = 0;
        if (rf_if.iss_en && ia != 0) m_busy[ia] = 1;
        m_busy[0] = 0;
    endfunction

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q [$];
    int n_checks = 0;
    int n_fail   = 0;

    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [W-1:0] g;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {rf_if.rd_data, rf_if.rd_busy, rf_if.busy_vec};
            n_checks += 3;
            if (g[W-1 -: NREAD*XLEN] !== e[W-1 -: NREAD*XLEN]) begin
                n_fail++;
                $display("FAIL rd_data t=%0t got %h exp %h", $time,
                         g[W-1 -: NREAD*XLEN], e[W-1 -: NREAD*XLEN]);
            end
            if (g[NREGS +: NREAD] !== e[NREGS +: NREAD]) begin
                n_fail++;
                $display("FAIL rd_busy t=%0t got %b exp %b", $time,
                         g[NREGS +: NREAD], e[NREGS +: NREAD]);
            end
            if (g[NREGS-1:0] !== e[NREGS-1:0]) begin
                n_fail++;
                $display("FAIL busy_vec t=%0t got %h exp %h", $time,
                         g[NREGS-1:0], e[NREGS-1:0]);
            end
        end
    end

    // ---------------- driver ----------------
    function automatic logic [NREAD*AW-1:0] ra(input int a0, input int a1,
                                                input int a2, input int a3);
        logic [AW-1:0] x0, x1, x2, x3;
        x0 = AW'(a0); x1 = AW'(a1); x2 = AW'(a2); x3 = AW'(a3);
        return {x3, x2, x1, x0};
    endfunction

    task automatic drive(input logic we, input int wa, input logic [XLEN-1:0] wd,
                         input logic ie, input int ia,
                         input logic [NREAD*AW-1:0] rda, input bit do_rst);
        @(posedge clk);
        #1;
        rf_if.wr_en    = we;
        rf_if.wr_addr  = AW'(wa);
        rf_if.wr_data  = wd;
        rf_if.iss_en   = ie;
        rf_if.iss_addr = AW'(ia);
        rf_if.rd_addr  = rda;
        if (do_rst) begin
            #1;
            reset = 1'b0;
            model_reset();
        end
        exp_q.push_back(expect_now());
        if (do_rst) begin
            @(negedge clk);
            #1;
            reset = 1'b1;
        end
        model_edge();
    endtask

    task automatic idle_read(input logic [NREAD*AW-1:0] rda);
        drive(1'b0, 0, '0, 1'b0, 0, rda, 1'b0);
    endtask

    function automatic int rnd_addr();
        if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 7));
        return int'($urandom_range(0, NREGS-1));
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        reset          = 1'b0;
        rf_if.wr_en    = 1'b0;
        rf_if.wr_addr  = '0;
        rf_if.wr_data  = '0;
        rf_if.iss_en   = 1'b0;
        rf_if.iss_addr = '0;
        rf_if.rd_addr  = ra(0, 1, 2, 63);
        model_reset();
        exp_q.push_back(expect_now());
        @(negedge clk);
        #1;
        reset = 1'b1;

        // Back-to-back writes, then read both.
        drive(1'b1, 2, 200, 1'b0, 0, ra(2, 5, 0, 0), 1'b0);
        drive(1'b1, 5, 10,  1'b0, 0, ra(2, 5, 2, 5), 1'b0);
        idle_read(ra(2, 5, 5, 2));

        // Writes and issues to r0 have no effect.
        drive(1'b1, 0, 32'hDEAD_BEEF, 1'b1, 0, ra(0, 0, 0, 0), 1'b0);
        idle_read(ra(0, 0, 0, 0));

        // Issue r7, then writeback while reading it.
        drive(1'b0, 0, '0, 1'b1, 7, ra(7, 0, 0, 0), 1'b0);
        idle_read(ra(7, 7, 0, 0));
        drive(1'b1, 7, 32'h55, 1'b0, 0, ra(7, 7, 2, 0), 1'b0);
        idle_read(ra(7, 7, 2, 0));

        // Same-edge issue and writeback to r9, then a second writeback.
        drive(1'b1, 9, 42, 1'b1, 9, ra(9, 0, 0, 0), 1'b0);
        idle_read(ra(9, 9, 0, 0));
        drive(1'b1, 9, 43, 1'b0, 0, ra(9, 0, 0, 0), 1'b0);
        idle_read(ra(9, 9, 0, 0));

        // Double issue needs only one writeback; writeback to idle register.
        drive(1'b0, 0, '0, 1'b1, 11, ra(11, 0, 0, 0), 1'b0);
        drive(1'b0, 0, '0, 1'b1, 11, ra(11, 0, 0, 0), 1'b0);
        drive(1'b1, 11, 77, 1'b1, 12, ra(11, 12, 0, 0), 1'b0);
        drive(1'b1, 13, 88, 1'b0, 0, ra(11, 12, 13, 0), 1'b0);
        idle_read(ra(11, 12, 13, 0));

        // Mid-cycle reset clears data and busy before the next edge.
        drive(1'b1, 2, 200, 1'b0, 0, ra(2, 5, 0, 0), 1'b0);
        drive(1'b1, 5, 10,  1'b0, 0, ra(2, 5, 0, 0), 1'b0);
        drive(1'b0, 0, '0, 1'b1, 5, ra(2, 5, 0, 0), 1'b0);
        drive(1'b0, 0, '0, 1'b0, 0, ra(2, 5, 5, 2), 1'b1);
        idle_read(ra(2, 5, 0, 0));

        // Top register and port aliasing.
        drive(1'b1, 63, 1, 1'b0, 0, ra(0, 63, 63, 31), 1'b0);
        drive(1'b1, 31, 2, 1'b0, 0, ra(0, 63, 63, 31), 1'b0);
        idle_read(ra(0, 63, 63, 31));

        // Random traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            logic [NREAD*AW-1:0] rda;
            bit do_rst;
            rda = ra(rnd_addr(), rnd_addr(), rnd_addr(), rnd_addr());
            do_rst = ($urandom_range(0, 59) == 0);
            if (do_rst) begin
                drive(1'b0, 0, '0, 1'b0, 0, rda, 1'b1);
            end else begin
                drive(1'($urandom_range(0, 1)), rnd_addr(), $urandom(),
                      1'($urandom_range(0, 1)), rnd_addr(), rda, 1'b0);
            end
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending exp 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
